// File: rtl/pokey_pkg.sv
// ============================================================================
//  Module   : pokey_pkg
//  Purpose  : Shared state encoding and default framing constants for the
//             POKEY-style serial transmitter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package pokey_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_STOP_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pokey_shift_tx.sv
// ============================================================================
//  Module   : pokey_shift_tx
//  Purpose  : Parallel-load, LSB-first shift register with a count of the
//             data bits already presented on the line.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pokey_shift_tx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              shift_i,
    output logic              bit_o,
    output logic              done_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = load_data_i;
            cnt_d   = '0;
        end else if (shift_i) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_o  = shift_q[0];
    // High once every data bit has been driven onto the line.
    assign done_o = (cnt_q == CNT_FULL);

endmodule

`default_nettype wire

// File: rtl/pokey_serout.sv
// ============================================================================
//  Module   : pokey_serout
//  Purpose  : POKEY serial output: holding register, framing FSM (start,
//             LSB-first data, stop) and IRQ-source status outputs.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pokey_serout
    import pokey_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STOP_BITS = DEF_STOP_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_tick,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              brk,
    output logic              sout,
    output logic              need_data,
    output logic              tx_done,
    output logic              busy
);

    localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

    state_e            state_q, state_d;
    logic              sout_q, sout_d;
    logic              need_data_q, need_data_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [1:0]        stop_cnt_q, stop_cnt_d;

    logic              w_xfer;
    logic              w_sh_shift;
    logic              w_sh_bit;
    logic              w_sh_done;

    pokey_shift_tx #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (w_xfer),
        .load_data_i (hold_q),
        .shift_i     (w_sh_shift),
        .bit_o       (w_sh_bit),
        .done_o      (w_sh_done)
    );

    always_comb begin
        state_d    = state_q;
        sout_d     = sout_q;
        stop_cnt_d = stop_cnt_q;
        w_xfer     = 1'b0;
        w_sh_shift = 1'b0;
        if (bit_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_full_q) begin
                        w_xfer  = 1'b1;
                        sout_d  = 1'b0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    w_sh_shift = 1'b1;
                    sout_d     = w_sh_bit;
                    state_d    = ST_DATA;
                end
                ST_DATA: begin
                    if (w_sh_done) begin
                        sout_d     = 1'b1;
                        stop_cnt_d = '0;
                        state_d    = ST_STOP;
                    end else begin
                        w_sh_shift = 1'b1;
                        sout_d     = w_sh_bit;
                    end
                end
                ST_STOP: begin
                    // Last stop bit: chain straight into the next frame if one is waiting.
                    if (stop_cnt_q == STOP_LAST) begin
                        if (hold_full_q) begin
                            w_xfer  = 1'b1;
                            sout_d  = 1'b0;
                            state_d = ST_START;
                        end else begin
                            sout_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    sout_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end

        need_data_d = w_xfer;
        // A write on the transfer edge wins: old data goes to the shifter, new data stays held.
        hold_d      = wr_en ? wr_data : hold_q;
        hold_full_d = wr_en | (hold_full_q & ~w_xfer);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sout_q      <= 1'b1;
            need_data_q <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            stop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sout_q      <= sout_d;
            need_data_q <= need_data_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            stop_cnt_q  <= stop_cnt_d;
        end
    end

    assign sout      = sout_q & ~brk;
    assign need_data = need_data_q;
    assign tx_done   = (state_q == ST_IDLE) & ~hold_full_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/pokey_serout.md
POKEY_SEROUT -- requirements
Module: pokey_serout

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the number of data bits per frame.
REQ-002 SHALL have parameter STOP_BITS, default 1, giving the number of stop bits per frame (1 or 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port bit_tick, input, 1 bit: one-clk pulse marking each serial bit boundary; it comes from the audio-channel divider chain.
REQ-006 SHALL have port wr_en, input, 1 bit: a one-clk strobe that writes wr_data into the holding register.
REQ-007 SHALL have port wr_data, input, DATA_W bits: the byte written by the CPU (SEROUT).
REQ-008 SHALL have port brk, input, 1 bit: force break; while high, sout is held at 0.
REQ-009 SHALL have port sout, output, 1 bit: the serial line; it idles at 1.
REQ-010 SHALL have port need_data, output, 1 bit: a one-clk pulse when the holding register transfers to the shifter (the serial-output-needed IRQ source).
REQ-011 SHALL have port tx_done, output, 1 bit: a level, high when the shifter is idle and the holding register is empty (the transmission-finished IRQ source).
REQ-012 SHALL have port busy, output, 1 bit: a level, high whenever the state is not IDLE.

Function
REQ-013 SHALL frame each word as start bit 0, then DATA_W data bits LSB first, then STOP_BITS stop bits of 1.
REQ-014 SHALL implement the states IDLE, START, DATA and STOP, advancing only on clk edges where bit_tick=1.
REQ-015 SHALL, in IDLE with the holding register full, on bit_tick: load the shifter from the holding register, clear the holding-full flag, pulse need_data and enter START.
REQ-016 SHALL leave sout equal to the start bit (0) from the START entry edge until the next bit_tick.
REQ-017 SHALL, on each bit_tick in START or DATA, present the next data bit on sout, counting DATA_W bits with a counter of width clog2(DATA_W+1).
REQ-018 SHALL, after the last data bit, enter STOP with sout=1 for STOP_BITS bit periods.
REQ-019 SHALL, on the bit_tick that ends the last stop bit, go directly to START (the REQ-015 transfer) if the holding register is full, giving back-to-back frames with no idle gap; otherwise it SHALL go to IDLE.
REQ-020 SHALL, on wr_en, capture wr_data into the holding register and set holding-full.
REQ-021 SHALL, on a write while holding-full is already set, overwrite the held data; no error is flagged.
REQ-022 SHALL, when wr_en and a transfer occur on the same edge, send the old held data to the shifter, while the holding register takes the new data and remains full.
REQ-023 SHALL, on a write to an empty holding register on a bit_tick edge in IDLE, perform no transfer that edge; the transfer happens at the next bit_tick.
REQ-024 SHALL make tx_done combinational from the registered state: (state==IDLE) & ~holding-full.
REQ-025 SHALL let brk override sout only; the state machine, the counters and need_data SHALL continue unaffected.
REQ-026 SHALL ignore wr_en and bit_tick during reset.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously set state=IDLE, sout=1, need_data=0, holding-full=0, holding and shift data=0, and the bit counter=0.
REQ-028 SHALL abort a frame in progress when reset is asserted mid-frame; after release, sout SHALL be 1 and tx_done SHALL be 1.

Structure
REQ-029 SHALL place the state encoding (IDLE/START/DATA/STOP) and the default DATA_W and STOP_BITS constants in the shared package pokey_pkg.
REQ-030 SHALL use one sub-module, pokey_shift_tx: a parallel-load, LSB-first shift register with a bit counter, controlled by the FSM in pokey_serout.
REQ-031 SHALL register sout; no combinational path SHALL exist from wr_en or bit_tick to sout.

Verification
REQ-032 SHALL cover a single frame: write 0xA5, then bit_tick every 4 clks -> sout sequence 0,1,0,1,0,0,1,0,1,1; one need_data pulse; tx_done rises after the stop bit.
REQ-033 SHALL cover back-to-back frames: write 0x3C, then write 0xFF during its DATA state -> the frames are contiguous, the second start bit immediately follows the first stop bit, there are 2 need_data pulses and tx_done stays 0 until the end.
REQ-034 SHALL cover overwrite: write 0x11 then 0x22 before any bit_tick, in IDLE -> only 0x22 is transmitted.
REQ-035 SHALL cover a simultaneous write and transfer: write 0x55 while full with 0x0F on the transfer edge -> 0x0F is sent, then 0x55.
REQ-036 SHALL cover break: brk=1 mid-frame for 3 bit_ticks -> sout=0 throughout, and the frame timing and need_data are unchanged.
REQ-037 SHALL cover reset mid-frame: assert rst_n=0 during DATA bit 3 -> sout=1 immediately, busy=0, tx_done=1; a fresh write of 0x81 then transmits correctly.
